// File: rtl/clkdiv_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration controller.
//   clkdiv_state_e : controller FSM states
//   CLKDIV_W       : width of a divisor value
//   CLKDIV_MIN_DIV : smallest divisor the divider can run with
//   clkdiv_div_ok  : divisor legality check
package clkdiv_ctrl_pkg;

  localparam int CLKDIV_W = 32;
  localparam logic [CLKDIV_W-1:0] CLKDIV_MIN_DIV = 32'd2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CHECK,
    HOLD,
    RESP
  } clkdiv_state_e;

  function automatic logic clkdiv_div_ok(input logic [CLKDIV_W-1:0] d);
    return (d >= CLKDIV_MIN_DIV);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req       : request vector, one bit per requester
//   ptr       : requester with highest priority this cycle
//   gnt_idx   : first requester at or after ptr (wrapping)
//   gnt_valid : at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW:0] k;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    k         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IW + 1)'(i);
      if (k >= (IW + 1)'(N)) begin
        k = k - (IW + 1)'(N);
      end
      if (req[k[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Configuration controller for the shared programmable clock divider.
// Requesters are arbitrated round-robin; a legal new divisor is applied
// while the divider is held in reset for HOLD_CYCLES cycles so the divided
// clock restarts cleanly from its high phase.
//   clk, rstn   : clock, asynchronous active-low reset
//   req_i       : per-requester level request, held until ack
//   div_i       : requested divisors, 32 bits per requester
//   ack_o       : one-cycle one-hot completion pulse
//   err_o       : request rejected (valid with ack_o)
//   busy_o      : controller not idle
//   divisor_o   : divisor to the divider
//   div_rstn_o  : active-low reset to the divider
module clkdiv_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int                  NREQ        = 2,
  parameter int                  HOLD_CYCLES = 2,
  parameter logic [CLKDIV_W-1:0] RESET_DIV   = 32'd2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_i,
  input  logic [CLKDIV_W*NREQ-1:0] div_i,
  output logic [NREQ-1:0]          ack_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [CLKDIV_W-1:0]      divisor_o,
  output logic                     div_rstn_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);

  clkdiv_state_e       state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [CLKDIV_W-1:0] cand_q, cand_d;
  logic                rej_q, rej_d;
  logic [CLKDIV_W-1:0] divisor_q, divisor_d;
  logic                div_rstn_q, div_rstn_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req       (req_i),
    .ptr       (ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cand_d     = cand_q;
    rej_d      = rej_q;
    divisor_d  = divisor_q;
    div_rstn_d = div_rstn_q;

    unique case (state_q)
      // The divider is released once the count expires; the controller
      // then spends one more cycle in INIT so the divider's first cycle
      // out of reset is not also the first cycle a request can be taken.
      INIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!div_rstn_q) begin
          div_rstn_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_idx;
          for (int k = 0; k < NREQ; k++) begin
            if (arb_idx == IW'(k)) begin
              cand_d = div_i[k*CLKDIV_W +: CLKDIV_W];
            end
          end
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!clkdiv_div_ok(cand_q)) begin
          rej_d   = 1'b1;
          state_d = RESP;
        end else if (cand_q == divisor_q) begin
          rej_d   = 1'b0;
          state_d = RESP;
        end else begin
          rej_d      = 1'b0;
          divisor_d  = cand_q;
          div_rstn_d = 1'b0;
          cnt_d      = CNT_INIT;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          div_rstn_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ack_d = '0;
    if (state_d == RESP) begin
      for (int k = 0; k < NREQ; k++) begin
        ack_d[k] = (gnt_d == IW'(k));
      end
    end
    err_d  = (state_d == RESP) ? rej_d : 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= INIT;
      cnt_q      <= CNT_INIT;
      ptr_q      <= '0;
      divisor_q  <= RESET_DIV;
      div_rstn_q <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      divisor_q  <= divisor_d;
      div_rstn_q <= div_rstn_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Transaction payload: only meaningful after a grant, so no reset needed.
  always_ff @(posedge clk) begin
    gnt_q  <= gnt_d;
    cand_q <= cand_d;
    rej_q  <= rej_d;
  end

  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign divisor_o  = divisor_q;
  assign div_rstn_o = div_rstn_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
module tb_clkdiv_ctrl;

  localparam int NREQ = 2;
  localparam int HOLD = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req_i;
  logic [32*NREQ-1:0] div_i;
  logic [NREQ-1:0]   ack_o;
  logic              err_o;
  logic              busy_o;
  logic [31:0]       divisor_o;
  logic              div_rstn_o;

  logic [31:0] divs [NREQ];

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_div;
  int          m_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_div
    assign div_i[32*g +: 32] = divs[g];
  end

  clkdiv_ctrl #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .RESET_DIV   (32'd2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_i      (req_i),
    .div_i      (div_i),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .divisor_o  (divisor_o),
    .div_rstn_o (div_rstn_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Served requester = first pending one at or after the pointer; a legal
  // different divisor costs 2+HOLD cycles, anything else 2.
  task automatic model_step(output int w, output logic e_err, output int e_lat,
                            output logic [31:0] e_div);
    logic [31:0] d;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (w < 0 && req_i[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
    end
    if (w < 0) w = 0;
    d = divs[w];
    if (d < 2) begin
      e_err = 1'b1; e_lat = 2;
    end else if (d == m_div) begin
      e_err = 1'b0; e_lat = 2;
    end else begin
      e_err = 1'b0; e_lat = 2 + HOLD; m_div = d;
    end
    m_ptr = (w + 1) % NREQ;
    e_div = m_div;
  endtask

  // Entered at a negedge of cycle t+start_n; returns at the negedge of the
  // IDLE cycle following the ack, with the served request dropped.
  task automatic run_txn(input string nm, input int w, input logic e_err, input int e_lat,
                         input logic [31:0] e_div, input int start_n);
    int n, low;
    bit seen;
    logic [31:0] prev;
    logic [NREQ-1:0] e_ack;
    n = start_n; low = 0; seen = 0; prev = divisor_o;
    e_ack = '0; e_ack[w] = 1'b1;
    while (!seen && n < 30) begin
      next_cycle();
      n++;
      if (!div_rstn_o) low++;
      chk({nm, "_div_change_while_running"},
          {31'b0, (divisor_o !== prev) && div_rstn_o}, 32'd0);
      prev = divisor_o;
      if (ack_o != '0) seen = 1;
    end
    chk({nm, "_ack_seen"}, {31'b0, seen}, 32'd1);
    chk({nm, "_latency"}, n, e_lat);
    chk({nm, "_ack_vec"}, {{(32-NREQ){1'b0}}, ack_o}, {{(32-NREQ){1'b0}}, e_ack});
    chk({nm, "_err"}, {31'b0, err_o}, {31'b0, e_err});
    chk({nm, "_divisor"}, divisor_o, e_div);
    chk({nm, "_rst_low_cycles"}, low, (e_lat == 2) ? 0 : HOLD);
    chk({nm, "_rstn_after"}, {31'b0, div_rstn_o}, 32'd1);
    req_i[w] = 1'b0;
    next_cycle();
    chk({nm, "_busy_idle"}, {31'b0, busy_o}, 32'd0);
    chk({nm, "_ack_once"}, {{(32-NREQ){1'b0}}, ack_o}, 32'd0);
  endtask

  // Called at the negedge on which rstn is released.
  task automatic check_init(input string nm);
    chk({nm, "_c0_rstn"}, {31'b0, div_rstn_o}, 32'd0);
    chk({nm, "_c0_busy"}, {31'b0, busy_o}, 32'd1);
    chk({nm, "_c0_div"}, divisor_o, 32'd2);
    chk({nm, "_c0_ack"}, {{(32-NREQ){1'b0}}, ack_o}, 32'd0);
    next_cycle();
    chk({nm, "_c1_rstn"}, {31'b0, div_rstn_o}, 32'd0);
    next_cycle();
    chk({nm, "_c2_rstn"}, {31'b0, div_rstn_o}, 32'd1);
    chk({nm, "_c2_busy"}, {31'b0, busy_o}, 32'd1);
    next_cycle();
    chk({nm, "_c3_busy"}, {31'b0, busy_o}, 32'd0);
    chk({nm, "_c3_rstn"}, {31'b0, div_rstn_o}, 32'd1);
    chk({nm, "_c3_div"}, divisor_o, 32'd2);
    chk({nm, "_c3_ack"}, {{(32-NREQ){1'b0}}, ack_o}, 32'd0);
    m_div = 32'd2;
    m_ptr = 0;
  endtask

  function automatic logic [31:0] rand_div();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return m_div;
      3: return 32'd2;
      4: return $urandom;
      default: return 32'($urandom_range(2, 40));
    endcase
  endfunction

  typedef struct {
    logic [NREQ-1:0] req;
    logic [31:0]     d0;
    logic [31:0]     d1;
    int              idx;
    logic            err;
    int              lat;
    logic [31:0]     dv;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int w, lat;
    logic err;
    logic [31:0] dv;
    logic [NREQ-1:0] mask;

    tbl[0] = '{2'b01, 32'd10, 32'd0, 0, 1'b0, 2 + HOLD, 32'd10};
    tbl[1] = '{2'b10, 32'd0,  32'd1, 1, 1'b1, 2,        32'd10};
    tbl[2] = '{2'b10, 32'd0,  32'd0, 1, 1'b1, 2,        32'd10};
    tbl[3] = '{2'b10, 32'd0, 32'd10, 1, 1'b0, 2,        32'd10};
    tbl[4] = '{2'b11, 32'd5,  32'd7, 0, 1'b0, 2 + HOLD, 32'd5};
    tbl[5] = '{2'b00, 32'd0,  32'd0, 1, 1'b0, 2 + HOLD, 32'd7};
    tbl[6] = '{2'b01, 32'd7,  32'd0, 0, 1'b0, 2,        32'd7};
    tbl[7] = '{2'b11, 32'd5,  32'd7, 1, 1'b0, 2,        32'd7};
    tbl[8] = '{2'b00, 32'd0,  32'd0, 0, 1'b0, 2 + HOLD, 32'd5};

    rstn  = 1'b0;
    req_i = '0;
    for (int k = 0; k < NREQ; k++) divs[k] = 32'd0;
    m_div = 32'd2;
    m_ptr = 0;

    repeat (2) @(negedge clk);
    chk("reset_div", divisor_o, 32'd2);
    chk("reset_rstn", {31'b0, div_rstn_o}, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd1);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    rstn = 1'b1;
    check_init("init");

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].req[0] && !req_i[0]) divs[0] = tbl[i].d0;
      if (tbl[i].req[1] && !req_i[1]) divs[1] = tbl[i].d1;
      req_i = req_i | tbl[i].req;
      model_step(w, err, lat, dv);
      run_txn($sformatf("vec%0d", i), tbl[i].idx, tbl[i].err, tbl[i].lat, tbl[i].dv, 0);
    end

    // Request dropped and divisor changed right after the grant
    divs[0] = 32'd12;
    req_i[0] = 1'b1;
    model_step(w, err, lat, dv);
    next_cycle();
    divs[0] = 32'd3;
    req_i[0] = 1'b0;
    run_txn("late_change", w, err, lat, dv, 1);

    // Reset pulsed during HOLD
    divs[1] = 32'd15;
    req_i[1] = 1'b1;
    repeat (3) next_cycle();
    chk("hold_rstn_low", {31'b0, div_rstn_o}, 32'd0);
    chk("hold_div_new", divisor_o, 32'd15);
    rstn = 1'b0;
    #1;
    chk("midrst_div", divisor_o, 32'd2);
    chk("midrst_rstn", {31'b0, div_rstn_o}, 32'd0);
    chk("midrst_ack", {{(32-NREQ){1'b0}}, ack_o}, 32'd0);
    chk("midrst_busy", {31'b0, busy_o}, 32'd1);
    req_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    check_init("reinit");

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      if (req_i == '0) mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      else mask = ($urandom_range(0, 1) == 1) ? ~req_i : '0;
      for (int k = 0; k < NREQ; k++) begin
        if (mask[k] && !req_i[k]) begin
          divs[k] = rand_div();
          req_i[k] = 1'b1;
        end
      end
      model_step(w, err, lat, dv);
      run_txn($sformatf("rnd%0d", it), w, err, lat, dv, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Configuration controller for the system's programmable clock divider. It shares the single divider between NREQ requesters (e.g. a CPU-side register block and a debug port) through round-robin arbitration. It validates each requested divisor and applies it by holding the divider in reset for a fixed quiet window, so the divided clock restarts cleanly from its high phase and never runs a mixed-divisor period. It drives the divider's `divisor` and `rstn` inputs directly.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (≥1).
- `HOLD_CYCLES`, 2: clk cycles the divider is held in reset per change (≥1).
- `RESET_DIV`, 32'd2: divisor value after reset (must be ≥2).

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `req_i`  in  NREQ: per-requester change request; level, held until ack.
- `div_i`  in  32*NREQ: requested divisor, slice k = bits [32k+31:32k]; stable while `req_i[k]`.
- `ack_o`  out  NREQ: one-cycle completion pulse, one-hot.
- `err_o`  out  1: valid with any `ack_o` bit; 1 = request rejected.
- `busy_o`  out  1: FSM not in IDLE.
- `divisor_o`  out  32: to divider `divisor`.
- `div_rstn_o`  out  1: to divider `rstn`, active-low.

## Operation
- States: INIT, IDLE, CHECK, HOLD, RESP.
- Reset values: state=INIT, `divisor_o`=RESET_DIV, `div_rstn_o`=0, `ack_o`=0, `err_o`=0, `busy_o`=1, hold counter=HOLD_CYCLES-1, RR pointer=0.
- INIT: counts down the hold counter; at 0 it sets `div_rstn_o`←1 and goes to IDLE.
- IDLE: if any `req_i` is set, the round-robin arbiter picks the first requester at or after the pointer (wrapping modulo NREQ). Register its index and `div_i` slice as the candidate. Pointer←index+1 mod NREQ. Go to CHECK. With no request, stay.
- CHECK:
  - Candidate < 2 (unsigned 32-bit): error=1, go to RESP; no output change.
  - Candidate == `divisor_o`: error=0, go to RESP; no divider reset.
  - Otherwise: `divisor_o`←candidate, `div_rstn_o`←0, counter←HOLD_CYCLES-1, go to HOLD.
- HOLD: decrement the counter. When the counter is 0: `div_rstn_o`←1, go to RESP.
- RESP: `ack_o[grant]`=1 and `err_o`=error, for exactly this cycle. Go to IDLE.
- `busy_o`=1 in every state except IDLE.
- `divisor_o` changes only while `div_rstn_o`=0 (the same edge that asserts it).
- Requesters drop `req_i` on the edge where they sample `ack_o`. The IDLE cycle after RESP therefore never re-grants the same transaction.
- Protocol violations:
  - `req_i` dropped before ack: the transaction still completes and acks.
  - `div_i` changed after the grant: ignored; the captured candidate is used.
- Simultaneous requests: exactly one grant per transaction; the others wait, each served within NREQ transactions.
- `rstn` asserted mid-operation: immediate return to the reset values, including `divisor_o`=RESET_DIV. The pending transaction is lost with no ack.

## Timing
- Requests are first seen in IDLE cycle t.
- Accepted change: `div_rstn_o` low in cycles t+2 … t+1+HOLD_CYCLES; ack in cycle t+2+HOLD_CYCLES.
- Reject or same-value: ack in cycle t+2; `div_rstn_o` stays 1.
- After `rstn` deasserts: `div_rstn_o` stays low for HOLD_CYCLES cycles, then goes high; IDLE from the following cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Back-to-back throughput: one transaction per 3+HOLD_CYCLES cycles (accepted change) or per 3 cycles (reject or same-value).

## Structure
- Package `clkdiv_ctrl_pkg`:
  - state enum `clkdiv_state_e` {INIT, IDLE, CHECK, HOLD, RESP};
  - constant `CLKDIV_MIN_DIV` = 32'd2;
  - constant `CLKDIV_W` = 32.
- Sub-module `rr_arbiter` (parameter N; inputs `req`, `ptr`; outputs `gnt_idx`, `gnt_valid`): combinational round-robin pick. The pointer register lives in `clkdiv_ctrl`.
- The FSM, candidate/error registers, hold counter and output registers live in `clkdiv_ctrl`.

## Test plan
- Reset release: `div_rstn_o`=0 for 2 cycles, then 1; `divisor_o`=2; `busy_o` falls one cycle after `div_rstn_o` rises.
- Requester 0 asks for divisor 10: `div_rstn_o` low in cycles t+2..t+3, `divisor_o`=10 from t+2, `ack_o`=2'b01 with `err_o`=0 at t+4. A connected divider then produces a 10-cycle period starting high.
- Requester 1 asks for divisor 1, then 0: each gives `ack_o`=2'b10, `err_o`=1 at t+2; `divisor_o` and `div_rstn_o` unchanged.
- Requesting the current divisor 10: ack at t+2, `err_o`=0, no `div_rstn_o` pulse.
- Both requesters raise `req_i` together (5 and 7), pointer=0: requester 0 served first (`divisor_o`=5), then requester 1 (`divisor_o`=7). Repeating the pair from pointer=1 serves requester 1 first.
- `rstn` pulsed low during HOLD: `divisor_o`=2, `div_rstn_o`=0, no ack issued, INIT sequence reruns.
